issue_ctrl: RTL and testbench
=============================

Name: issue_ctrl

Overview:
- In-order issue scheduler between the register-file stage and the execution units (ALU/BRU/LSU/SYS).
- Holds decoded instructions until their operands and destination are free of pending writes, LSU credits are available and serialization conditions are met.
- Issues instructions through a one-entry registered output slot.
- Owns the per-register pending-write scoreboard and the LSU credit counter, and undoes slot state on flush.

Parameters:
- MAX_PENDING, 3: max outstanding writes per architectural register; counter width is $clog2(MAX_PENDING+1).
- LSU_CREDITS, 2: max LSU operations issued but not yet completed.

Ports:
- clk  in  1  clock
- rst  in  1  reset; synchronous, active-low
- in_tvalid  in  1  decoded instruction valid
- in_tready  out  1  instruction accepted this cycle
- in_rs1  in  5  source reg 1 (0 = unused)
- in_rs2  in  5  source reg 2 (0 = unused)
- in_rd  in  5  destination (0 = no write)
- in_unit  in  2  0 ALU, 1 BRU, 2 LSU, 3 SYS
- in_serialize  in  1  wait for full drain before issue (fence_i, CSR/xRET)
- out_tvalid  out  1  issue slot valid
- out_tready  in  1  target unit accepts
- out_rs1/out_rs2/out_rd  out  5 each  registered copies
- out_unit  out  2  registered copy
- wb_valid  in  1  register writeback retire
- wb_rd  in  5  retired destination
- lsu_done  in  1  one LSU op completed; returns a credit
- flush  in  1  pipeline invalidate
- busy_vec  out  32  bit i = pending[i] != 0; bit 0 always 0
- err  out  1  sticky protocol error

Behaviour:
- Reset (rst==0 at posedge): all pending counters 0, credits = LSU_CREDITS, out_tvalid 0, out_* fields 0, err 0.
- Slot free: slot_free = !out_tvalid || out_tready.
- Hazard: stall if any of the following holds:
  - (in_rs1!=0 && pending[in_rs1]!=0)
  - (in_rs2!=0 && pending[in_rs2]!=0)
  - (in_rd!=0 && pending[in_rd]==MAX_PENDING)
  - (in_unit==LSU && credits==0)
  - (in_serialize && (busy_vec!=0 || credits!=LSU_CREDITS || out_tvalid))
- Ready: in_tready = slot_free && !hazard && !flush. Combinational, and independent of in_tvalid, so no loop.
- Accept (in_tvalid && in_tready):
  - Next cycle the slot holds the instruction (latency 1), out_tvalid = 1.
  - pending[in_rd]++ if in_rd!=0.
  - credits-- if LSU.
- Slot hold: if out_tvalid && !out_tready and no flush, all out_* fields stay stable.
- Writeback (wb_valid):
  - pending[wb_rd]-- when wb_rd!=0 and the count is nonzero.
  - wb_valid with count 0 → counter unchanged, err set.
  - wb_rd==0 is ignored.
- Simultaneous increment and decrement on the same register: net unchanged. Wrap is impossible, because increment is gated by the MAX_PENDING stall and decrement by the zero check.
- lsu_done: credits++. If credits==LSU_CREDITS and no same-cycle consume, ignore and set err. lsu_done with a same-cycle consume: net unchanged.
- Flush:
  - Next cycle out_tvalid = 0.
  - If the slot held a valid, unconsumed entry (out_tvalid && !out_tready), undo it: pending[out_rd]-- (if out_rd!=0) and credits++ (if out_unit==LSU).
  - Undo combines with same-cycle wb/lsu_done arithmetically; e.g. undo plus wb on the same reg = −2.
  - If out_tready is high during flush, the handshake completes and nothing is undone.
  - Counters for instructions past the slot are not cleared; their writebacks still arrive.
- Hazard checks use only register state. A same-cycle wb does not bypass into the stall decision, which costs one bubble.
- Priority: rst > flush > normal.
- err clears only on reset.

Test Plan:
- RAW: issue rd=5 (ALU); next in_rs1=5 → in_tready=0, busy_vec[5]=1; wb_rd=5 at cycle 4 → accepted cycle 5, busy_vec[5]=0 after.
- Saturation: 3 accepted instrs with rd=7 and no wb → 4th rd=7 stalls; one wb_rd=7 → 4th accepted next cycle; pending[7] stays 3.
- LSU credits: 3 back-to-back LSU, out_tready=1 → 3rd stalls until lsu_done; lsu_done with 2 credits free → err=1.
- Serialize: in_serialize with one outstanding ALU rd=3 → stalls; wb_rd=3 with slot empty → issues next cycle; busy_vec=0.
- Flush undo: slot holds LSU rd=9, out_tready=0, flush=1 → next cycle out_tvalid=0, busy_vec[9]=0, credits=2; in_tready=0 during the flush cycle.
- Edge cases:
  - wb_rd=4 and accept rd=4 in the same cycle with pending[4]=1 → pending stays 1.
  - rst low mid-stream → all outputs at reset values next cycle.

Source files
------------

// File: rtl/issue_ctrl.sv
// In-order issue scheduler: holds one decoded instruction until it is free of RAW/WAW,
// LSU-credit and serialization hazards, then issues it through a one-entry registered slot.
module issue_ctrl #(
  parameter int MAX_PENDING = 3,
  parameter int LSU_CREDITS = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_tvalid,
  output logic        in_tready,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [4:0]  in_rd,
  input  logic [1:0]  in_unit,
  input  logic        in_serialize,
  output logic        out_tvalid,
  input  logic        out_tready,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [4:0]  out_rd,
  output logic [1:0]  out_unit,
  input  logic        wb_valid,
  input  logic [4:0]  wb_rd,
  input  logic        lsu_done,
  input  logic        flush,
  output logic [31:0] busy_vec,
  output logic        err
);

  localparam int PW = $clog2(MAX_PENDING + 1);
  localparam int CW = $clog2(LSU_CREDITS + 1);
  localparam logic [1:0] UNIT_LSU = 2'd2;

  // Both handshakes are strict valid/ready: a transfer happens on a rising edge where
  // valid && ready; ready never depends on valid, and a raised valid holds its payload.

  logic [PW-1:0] pending_q [32];
  logic [PW-1:0] pending_d [32];
  logic [CW-1:0] credits_q, credits_d;
  logic          out_tvalid_q, out_tvalid_d;
  logic [4:0]    out_rs1_q, out_rs1_d;
  logic [4:0]    out_rs2_q, out_rs2_d;
  logic [4:0]    out_rd_q, out_rd_d;
  logic [1:0]    out_unit_q, out_unit_d;
  logic          err_q, err_d;

  logic slot_free, hazard, accept, undo, lsu_consume, lsu_ret, lsu_err, wb_err;

  // Saturating-at-zero arithmetic; the undo path can stack two decrements in one cycle.
  function automatic logic [PW-1:0] pend_next(input logic [PW-1:0] cur, input logic inc,
                                               input logic dec_a, input logic dec_b);
    int v;
    v = int'(cur) + int'(inc) - int'(dec_a) - int'(dec_b);
    if (v < 0) v = 0;
    return PW'(v);
  endfunction

  function automatic logic [CW-1:0] credit_next(input logic [CW-1:0] cur, input logic take,
                                                input logic give_a, input logic give_b);
    int v;
    v = int'(cur) - int'(take) + int'(give_a) + int'(give_b);
    if (v > LSU_CREDITS) v = LSU_CREDITS;
    if (v < 0) v = 0;
    return CW'(v);
  endfunction

  always_comb begin
    busy_vec = '0;
    for (int i = 1; i < 32; i++) begin
      busy_vec[i] = (pending_q[i] != '0);
    end
  end

  assign slot_free = !out_tvalid_q || out_tready;

  // Stall decision reads registered state only; a same-cycle writeback is not bypassed.
  always_comb begin
    hazard = 1'b0;
    if (in_rs1 != 5'd0 && pending_q[in_rs1] != '0) hazard = 1'b1;
    if (in_rs2 != 5'd0 && pending_q[in_rs2] != '0) hazard = 1'b1;
    if (in_rd != 5'd0 && pending_q[in_rd] == PW'(MAX_PENDING)) hazard = 1'b1;
    if (in_unit == UNIT_LSU && credits_q == '0) hazard = 1'b1;
    if (in_serialize && (busy_vec != '0 || credits_q != CW'(LSU_CREDITS) || out_tvalid_q))
      hazard = 1'b1;
  end

  assign in_tready   = slot_free && !hazard && !flush;
  assign accept      = in_tvalid && in_tready;
  assign undo        = flush && out_tvalid_q && !out_tready;
  assign lsu_consume = accept && (in_unit == UNIT_LSU);
  assign lsu_ret     = lsu_done && (credits_q != CW'(LSU_CREDITS) || lsu_consume);
  assign lsu_err     = lsu_done && (credits_q == CW'(LSU_CREDITS)) && !lsu_consume;
  assign wb_err      = wb_valid && (wb_rd != 5'd0) && (pending_q[wb_rd] == '0);

  always_comb begin
    for (int i = 0; i < 32; i++) begin
      pending_d[i] = pend_next(pending_q[i],
                               accept && (in_rd == 5'(i)) && (i != 0),
                               wb_valid && (wb_rd == 5'(i)) && (i != 0) && (pending_q[i] != '0),
                               undo && (out_rd_q == 5'(i)) && (i != 0));
    end
  end

  assign credits_d = credit_next(credits_q, lsu_consume, lsu_ret,
                                 undo && (out_unit_q == UNIT_LSU));
  assign err_d     = err_q || wb_err || lsu_err;

  // Issue slot: flush empties it, otherwise load on accept or drain on out_tready.
  always_comb begin
    out_tvalid_d = out_tvalid_q;
    out_rs1_d    = out_rs1_q;
    out_rs2_d    = out_rs2_q;
    out_rd_d     = out_rd_q;
    out_unit_d   = out_unit_q;
    if (flush) begin
      out_tvalid_d = 1'b0;
    end else if (accept) begin
      out_tvalid_d = 1'b1;
      out_rs1_d    = in_rs1;
      out_rs2_d    = in_rs2;
      out_rd_d     = in_rd;
      out_unit_d   = in_unit;
    end else if (out_tready) begin
      out_tvalid_d = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < 32; i++) pending_q[i] <= '0;
      credits_q    <= CW'(LSU_CREDITS);
      out_tvalid_q <= 1'b0;
      out_rs1_q    <= '0;
      out_rs2_q    <= '0;
      out_rd_q     <= '0;
      out_unit_q   <= '0;
      err_q        <= 1'b0;
    end else begin
      for (int i = 0; i < 32; i++) pending_q[i] <= pending_d[i];
      credits_q    <= credits_d;
      out_tvalid_q <= out_tvalid_d;
      out_rs1_q    <= out_rs1_d;
      out_rs2_q    <= out_rs2_d;
      out_rd_q     <= out_rd_d;
      out_unit_q   <= out_unit_d;
      err_q        <= err_d;
    end
  end

  assign out_tvalid = out_tvalid_q;
  assign out_rs1    = out_rs1_q;
  assign out_rs2    = out_rs2_q;
  assign out_rd     = out_rd_q;
  assign out_unit   = out_unit_q;
  assign err        = err_q;

endmodule

// File: tb/tb_issue_ctrl.sv
// Directed bench for issue_ctrl: each task drives one scenario and checks hand-computed values.
module tb_issue_ctrl;

  logic        clk;
  logic        rst;
  logic        in_tvalid;
  logic        in_tready;
  logic [4:0]  in_rs1, in_rs2, in_rd;
  logic [1:0]  in_unit;
  logic        in_serialize;
  logic        out_tvalid;
  logic        out_tready;
  logic [4:0]  out_rs1, out_rs2, out_rd;
  logic [1:0]  out_unit;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic        lsu_done;
  logic        flush;
  logic [31:0] busy_vec;
  logic        err;

  int n_checks = 0;
  int n_fail   = 0;

  issue_ctrl #(.MAX_PENDING(3), .LSU_CREDITS(2)) dut (
    .clk(clk), .rst(rst),
    .in_tvalid(in_tvalid), .in_tready(in_tready),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_rd(in_rd), .in_unit(in_unit),
    .in_serialize(in_serialize),
    .out_tvalid(out_tvalid), .out_tready(out_tready),
    .out_rs1(out_rs1), .out_rs2(out_rs2), .out_rd(out_rd), .out_unit(out_unit),
    .wb_valid(wb_valid), .wb_rd(wb_rd), .lsu_done(lsu_done), .flush(flush),
    .busy_vec(busy_vec), .err(err)
  );

  // Clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Inputs change 1 time unit after a rising edge, outputs are sampled there too.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    in_tvalid = 0; in_rs1 = 0; in_rs2 = 0; in_rd = 0; in_unit = 0; in_serialize = 0;
    out_tready = 1; wb_valid = 0; wb_rd = 0; lsu_done = 0; flush = 0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 0;
    tick(); tick();
    if (out_tvalid !== 1'b0) begin $display("FAIL reset_out_tvalid got %0b want 0", out_tvalid); n_fail++; end n_checks++;
    if ({out_rs1, out_rs2, out_rd, out_unit} !== 17'd0) begin $display("FAIL reset_out_fields got %h want 0", {out_rs1, out_rs2, out_rd, out_unit}); n_fail++; end n_checks++;
    if (busy_vec !== 32'd0) begin $display("FAIL reset_busy_vec got %h want 0", busy_vec); n_fail++; end n_checks++;
    if (err !== 1'b0) begin $display("FAIL reset_err got %0b want 0", err); n_fail++; end n_checks++;
    rst = 1;
    tick();
    if (in_tready !== 1'b1) begin $display("FAIL reset_in_tready got %0b want 1", in_tready); n_fail++; end n_checks++;
  endtask

  task automatic test_raw();
    idle_inputs();
    in_tvalid = 1; in_rd = 5; in_unit = 0;
    #1;
    if (in_tready !== 1'b1) begin $display("FAIL raw_first_ready got %0b want 1", in_tready); n_fail++; end n_checks++;
    tick();
    if (out_tvalid !== 1'b1 || out_rd !== 5'd5) begin $display("FAIL raw_slot got v=%0b rd=%0d want v=1 rd=5", out_tvalid, out_rd); n_fail++; end n_checks++;
    if (busy_vec[5] !== 1'b1) begin $display("FAIL raw_busy5 got %0b want 1", busy_vec[5]); n_fail++; end n_checks++;
    in_rd = 0; in_rs1 = 5;
    #1;
    if (in_tready !== 1'b0) begin $display("FAIL raw_stall got %0b want 0", in_tready); n_fail++; end n_checks++;
    tick();
    if (in_tready !== 1'b0 || out_tvalid !== 1'b0) begin $display("FAIL raw_stall2 got rdy=%0b v=%0b want 0 0", in_tready, out_tvalid); n_fail++; end n_checks++;
    wb_valid = 1; wb_rd = 5;
    #1;
    if (in_tready !== 1'b0) begin $display("FAIL raw_no_bypass got %0b want 0", in_tready); n_fail++; end n_checks++;
    tick();
    wb_valid = 0; wb_rd = 0;
    #1;
    if (in_tready !== 1'b1 || busy_vec[5] !== 1'b0) begin $display("FAIL raw_release got rdy=%0b busy5=%0b want 1 0", in_tready, busy_vec[5]); n_fail++; end n_checks++;
    tick();
    if (out_tvalid !== 1'b1 || out_rs1 !== 5'd5) begin $display("FAIL raw_issue got v=%0b rs1=%0d want 1 5", out_tvalid, out_rs1); n_fail++; end n_checks++;
    in_tvalid = 0; in_rs1 = 0;
    tick();
  endtask

  task automatic test_saturation();
    idle_inputs();
    in_tvalid = 1; in_rd = 7;
    for (int k = 0; k < 3; k++) begin
      #1;
      if (in_tready !== 1'b1) begin $display("FAIL sat_accept%0d got %0b want 1", k, in_tready); n_fail++; end n_checks++;
      tick();
    end
    if (busy_vec[7] !== 1'b1) begin $display("FAIL sat_busy7 got %0b want 1", busy_vec[7]); n_fail++; end n_checks++;
    if (in_tready !== 1'b0) begin $display("FAIL sat_stall got %0b want 0", in_tready); n_fail++; end n_checks++;
    wb_valid = 1; wb_rd = 7;
    #1;
    if (in_tready !== 1'b0) begin $display("FAIL sat_no_bypass got %0b want 0", in_tready); n_fail++; end n_checks++;
    tick();
    wb_valid = 0; wb_rd = 0;
    #1;
    if (in_tready !== 1'b1) begin $display("FAIL sat_release got %0b want 1", in_tready); n_fail++; end n_checks++;
    tick();
    if (in_tready !== 1'b0) begin $display("FAIL sat_full_again got %0b want 0", in_tready); n_fail++; end n_checks++;
    in_tvalid = 0; in_rd = 0;
    wb_valid = 1; wb_rd = 7;
    tick(); tick(); tick();
    wb_valid = 0; wb_rd = 0;
    #1;
    if (busy_vec[7] !== 1'b0 || err !== 1'b0) begin $display("FAIL sat_drain got busy7=%0b err=%0b want 0 0", busy_vec[7], err); n_fail++; end n_checks++;
  endtask

  task automatic test_serialize();
    idle_inputs();
    in_tvalid = 1; in_rd = 3; in_unit = 0;
    tick();
    in_rd = 0; in_unit = 3; in_serialize = 1;
    #1;
    if (in_tready !== 1'b0) begin $display("FAIL ser_stall_slot got %0b want 0", in_tready); n_fail++; end n_checks++;
    tick();
    if (in_tready !== 1'b0) begin $display("FAIL ser_stall_busy got %0b want 0", in_tready); n_fail++; end n_checks++;
    wb_valid = 1; wb_rd = 3;
    tick();
    wb_valid = 0; wb_rd = 0;
    #1;
    if (in_tready !== 1'b1 || busy_vec !== 32'd0) begin $display("FAIL ser_release got rdy=%0b busy=%h want 1 0", in_tready, busy_vec); n_fail++; end n_checks++;
    tick();
    if (out_tvalid !== 1'b1 || out_unit !== 2'd3) begin $display("FAIL ser_issue got v=%0b unit=%0d want 1 3", out_tvalid, out_unit); n_fail++; end n_checks++;
    idle_inputs();
    tick();
  endtask

  task automatic test_same_cycle();
    idle_inputs();
    in_tvalid = 1; in_rd = 4;
    tick();
    wb_valid = 1; wb_rd = 4;
    #1;
    if (in_tready !== 1'b1) begin $display("FAIL same_ready got %0b want 1", in_tready); n_fail++; end n_checks++;
    tick();
    in_tvalid = 0; in_rd = 0;
    if (busy_vec[4] !== 1'b1) begin $display("FAIL same_net_zero got %0b want 1", busy_vec[4]); n_fail++; end n_checks++;
    tick();
    wb_valid = 0; wb_rd = 0;
    #1;
    if (busy_vec[4] !== 1'b0 || err !== 1'b0) begin $display("FAIL same_drain got busy4=%0b err=%0b want 0 0", busy_vec[4], err); n_fail++; end n_checks++;
  endtask

  task automatic test_flush_undo();
    idle_inputs();
    out_tready = 0;
    in_tvalid = 1; in_rd = 9; in_unit = 2;
    tick();
    in_tvalid = 0; in_rd = 0; in_unit = 0;
    if (out_tvalid !== 1'b1 || out_rd !== 5'd9 || out_unit !== 2'd2 || busy_vec[9] !== 1'b1) begin $display("FAIL flush_load got v=%0b rd=%0d unit=%0d busy9=%0b want 1 9 2 1", out_tvalid, out_rd, out_unit, busy_vec[9]); n_fail++; end n_checks++;
    tick();
    if (out_tvalid !== 1'b1 || out_rd !== 5'd9) begin $display("FAIL flush_hold got v=%0b rd=%0d want 1 9", out_tvalid, out_rd); n_fail++; end n_checks++;
    flush = 1; in_tvalid = 1;
    #1;
    if (in_tready !== 1'b0) begin $display("FAIL flush_ready got %0b want 0", in_tready); n_fail++; end n_checks++;
    tick();
    flush = 0; in_tvalid = 0;
    if (out_tvalid !== 1'b0 || busy_vec[9] !== 1'b0) begin $display("FAIL flush_undo got v=%0b busy9=%0b want 0 0", out_tvalid, busy_vec[9]); n_fail++; end n_checks++;
    // Both LSU credits must be back: two LSU ops accepted, a third stalls.
    out_tready = 1; in_tvalid = 1; in_unit = 2;
    #1;
    if (in_tready !== 1'b1) begin $display("FAIL flush_credit1 got %0b want 1", in_tready); n_fail++; end n_checks++;
    tick();
    if (in_tready !== 1'b1) begin $display("FAIL flush_credit2 got %0b want 1", in_tready); n_fail++; end n_checks++;
    tick();
    if (in_tready !== 1'b0) begin $display("FAIL flush_credit3 got %0b want 0", in_tready); n_fail++; end n_checks++;
    in_tvalid = 0; in_unit = 0;
    lsu_done = 1;
    tick(); tick();
    lsu_done = 0;
    // Flush while the unit takes the slot: handshake completes, nothing undone.
    in_tvalid = 1; in_rd = 10;
    tick();
    in_tvalid = 0; in_rd = 0; flush = 1;
    tick();
    flush = 0;
    if (out_tvalid !== 1'b0 || busy_vec[10] !== 1'b1) begin $display("FAIL flush_taken got v=%0b busy10=%0b want 0 1", out_tvalid, busy_vec[10]); n_fail++; end n_checks++;
    wb_valid = 1; wb_rd = 10;
    tick();
    wb_valid = 0; wb_rd = 0;
    if (busy_vec !== 32'd0 || err !== 1'b0) begin $display("FAIL flush_clean got busy=%h err=%0b want 0 0", busy_vec, err); n_fail++; end n_checks++;
  endtask

  task automatic test_wb_err();
    idle_inputs();
    wb_valid = 1; wb_rd = 12;
    tick();
    wb_valid = 0; wb_rd = 0;
    if (err !== 1'b1 || busy_vec !== 32'd0) begin $display("FAIL wb_err got err=%0b busy=%h want 1 0", err, busy_vec); n_fail++; end n_checks++;
    tick();
    if (err !== 1'b1) begin $display("FAIL wb_err_sticky got %0b want 1", err); n_fail++; end n_checks++;
  endtask

  task automatic test_reset_midstream();
    idle_inputs();
    out_tready = 0;
    in_tvalid = 1; in_rs1 = 1; in_rs2 = 2; in_rd = 6; in_unit = 1;
    tick();
    idle_inputs();
    out_tready = 0;
    if (out_tvalid !== 1'b1 || out_rd !== 5'd6) begin $display("FAIL mid_load got v=%0b rd=%0d want 1 6", out_tvalid, out_rd); n_fail++; end n_checks++;
    rst = 0;
    tick();
    if (out_tvalid !== 1'b0 || {out_rs1, out_rs2, out_rd, out_unit} !== 17'd0) begin $display("FAIL mid_reset_slot got v=%0b f=%h want 0 0", out_tvalid, {out_rs1, out_rs2, out_rd, out_unit}); n_fail++; end n_checks++;
    if (busy_vec !== 32'd0 || err !== 1'b0) begin $display("FAIL mid_reset_state got busy=%h err=%0b want 0 0", busy_vec, err); n_fail++; end n_checks++;
    rst = 1;
    out_tready = 1;
    tick();
  endtask

  task automatic test_lsu_credits();
    idle_inputs();
    in_tvalid = 1; in_unit = 2;
    tick(); tick();
    if (in_tready !== 1'b0) begin $display("FAIL lsu_stall got %0b want 0", in_tready); n_fail++; end n_checks++;
    lsu_done = 1;
    #1;
    if (in_tready !== 1'b0) begin $display("FAIL lsu_no_bypass got %0b want 0", in_tready); n_fail++; end n_checks++;
    tick();
    lsu_done = 0;
    #1;
    if (in_tready !== 1'b1) begin $display("FAIL lsu_release got %0b want 1", in_tready); n_fail++; end n_checks++;
    tick();
    in_tvalid = 0; in_unit = 0;
    if (out_tvalid !== 1'b1 || out_unit !== 2'd2) begin $display("FAIL lsu_issue got v=%0b unit=%0d want 1 2", out_tvalid, out_unit); n_fail++; end n_checks++;
    lsu_done = 1;
    tick(); tick();
    if (err !== 1'b0) begin $display("FAIL lsu_return_ok got %0b want 0", err); n_fail++; end n_checks++;
    tick();
    lsu_done = 0;
    if (err !== 1'b1) begin $display("FAIL lsu_over_return got %0b want 1", err); n_fail++; end n_checks++;
  endtask

  initial begin
    test_reset();
    test_raw();
    test_saturation();
    test_serialize();
    test_same_cycle();
    test_flush_undo();
    test_wb_err();
    test_reset_midstream();
    test_lsu_credits();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
